// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined N-way select stage.
//   pipe_state_e : occupancy of the main/skid register pair
//   NUM_IN_MIN/MAX : legal range for the number of selectable inputs
package pipe_pkg;

  localparam int unsigned NUM_IN_MIN = 2;
  localparam int unsigned NUM_IN_MAX = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/muxn_sel.sv
// Combinational N-way word select with out-of-range detection.
//   in_data_i : NUM_IN flattened words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sel_i     : word index
//   data_c    : selected word, all zeros when sel_i >= NUM_IN
//   err_c     : high when sel_i >= NUM_IN
module muxn_sel
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_IN     = 4
) (
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
  input  logic [$clog2(NUM_IN)-1:0]    sel_i,
  output logic [DATA_WIDTH-1:0]        data_c,
  output logic                         err_c
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_IN);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("muxn_sel: NUM_IN out of range");
  end

  // Unmatched indices fall through to zero data with the error flag set.
  always_comb begin
    data_c = '0;
    err_c  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_WIDTH'(k)) begin
        data_c = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        err_c  = 1'b0;
      end
    end
  end

endmodule : muxn_sel

// File: rtl/pipe_muxn.sv
// Registered N-way select stage with valid/ready handshake and a skid slot.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : NUM_IN flattened input words
//   sel        : input index, captured with in_data on accept
//   in_valid   : upstream offer;  in_ready : stage can accept (registered)
//   flush      : drop all held entries
//   out_data   : selected word (registered); out_valid : out_data valid
//   out_ready  : downstream accepts;  sel_err : held entry had out-of-range sel
module pipe_muxn
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sel_err
);

  pipe_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic                  main_err_q, main_err_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_err_q, skid_err_d;
  logic                  out_valid_q;
  logic                  in_ready_q;

  logic [DATA_WIDTH-1:0] mux_data_c;
  logic                  mux_err_c;
  logic                  accept_c;
  logic                  emit_c;

  // Word select ahead of the storage registers.
  muxn_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_IN     (NUM_IN)
  ) u_muxn_sel (
    .in_data_i (in_data),
    .sel_i     (sel),
    .data_c    (mux_data_c),
    .err_c     (mux_err_c)
  );

  // Handshakes use only registered flags, so out_ready never reaches in_ready.
  assign accept_c = in_valid && in_ready_q;
  assign emit_c   = out_valid_q && out_ready;

  // Next-state and storage steering.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_err_d = main_err_q;
    skid_d     = skid_q;
    skid_err_d = skid_err_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d    = ST_ONE;
          main_d     = mux_data_c;
          main_err_d = mux_err_c;
        end
      end
      ST_ONE: begin
        if (accept_c && !emit_c) begin
          state_d    = ST_TWO;
          skid_d     = mux_data_c;
          skid_err_d = mux_err_c;
        end else if (accept_c && emit_c) begin
          main_d     = mux_data_c;
          main_err_d = mux_err_c;
        end else if (emit_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (emit_c) begin
          state_d    = ST_ONE;
          main_d     = skid_q;
          main_err_d = skid_err_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush overrides any accept or emit in the same cycle; data words hold.
    if (flush) begin
      state_d    = ST_EMPTY;
      main_d     = main_q;
      main_err_d = 1'b0;
      skid_d     = skid_q;
      skid_err_d = 1'b0;
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      main_err_q  <= 1'b0;
      skid_q      <= '0;
      skid_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      main_err_q  <= main_err_d;
      skid_q      <= skid_d;
      skid_err_q  <= skid_err_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
    end
  end

  assign out_data  = main_q;
  assign sel_err   = main_err_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule : pipe_muxn

// File: tb/tb_pipe_muxn.sv
// Directed bench for pipe_muxn: a 4-input 32-bit instance and a 3-input
// 8-bit instance for out-of-range select.
module tb_pipe_muxn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NUM_IN=4, DATA_WIDTH=32
  logic [127:0] in_data_a;
  logic [1:0]   sel_a;
  logic         in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, sel_err_a;
  logic [31:0]  out_data_a;

  // Instance B: NUM_IN=3, DATA_WIDTH=8
  logic [23:0]  in_data_b;
  logic [1:0]   sel_b;
  logic         in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, sel_err_b;
  logic [7:0]   out_data_b;

  int n_pass = 0;
  int n_total = 0;

  pipe_muxn #(.DATA_WIDTH(32), .NUM_IN(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .sel(sel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .flush(flush_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .sel_err(sel_err_a)
  );

  pipe_muxn #(.DATA_WIDTH(8), .NUM_IN(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .sel(sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sel_err(sel_err_b)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid_a); else n_pass++;
    n_total++; if (out_data_a !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data_a); else n_pass++;
    n_total++; if (sel_err_a !== 1'b0) $display("FAIL reset_sel_err got %b want 0", sel_err_a); else n_pass++;
    n_total++; if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready_a); else n_pass++;
    n_total++; if (in_ready_b !== 1'b1) $display("FAIL reset_in_ready_b got %b want 1", in_ready_b); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    in_valid_a = 1'b1; sel_a = 2'd2; out_ready_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    n_total++; if (out_valid_a !== 1'b1) $display("FAIL basic_out_valid got %b want 1", out_valid_a); else n_pass++;
    n_total++; if (out_data_a !== 32'hC) $display("FAIL basic_out_data got %h want c", out_data_a); else n_pass++;
    n_total++; if (sel_err_a !== 1'b0) $display("FAIL basic_sel_err got %b want 0", sel_err_a); else n_pass++;
    step();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL basic_drain got %b want 0", out_valid_a); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; sel_a = 2'd0;
    step();
    n_total++; if (out_data_a !== 32'hA || in_ready_a !== 1'b1) $display("FAIL bp_first got data=%h rdy=%b want a/1", out_data_a, in_ready_a); else n_pass++;
    sel_a = 2'd1;
    step();
    n_total++; if (in_ready_a !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready_a); else n_pass++;
    sel_a = 2'd2;
    step();
    n_total++; if (out_data_a !== 32'hA || out_valid_a !== 1'b1) $display("FAIL bp_hold got data=%h vld=%b want a/1", out_data_a, out_valid_a); else n_pass++;
    n_total++; if (in_ready_a !== 1'b0) $display("FAIL bp_third_blocked got %b want 0", in_ready_a); else n_pass++;
    out_ready_a = 1'b1;
    step();
    n_total++; if (out_data_a !== 32'hB || in_ready_a !== 1'b1) $display("FAIL bp_second got data=%h rdy=%b want b/1", out_data_a, in_ready_a); else n_pass++;
    step();
    in_valid_a = 1'b0;
    n_total++; if (out_data_a !== 32'hC || out_valid_a !== 1'b1) $display("FAIL bp_third got data=%h vld=%b want c/1", out_data_a, out_valid_a); else n_pass++;
    step();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid_a); else n_pass++;
  endtask

  task automatic test_sel_err();
    out_ready_b = 1'b1;
    in_valid_b = 1'b1; sel_b = 2'd3;
    step();
    n_total++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h00) $display("FAIL oor_data got vld=%b data=%h want 1/00", out_valid_b, out_data_b); else n_pass++;
    n_total++; if (sel_err_b !== 1'b1) $display("FAIL oor_sel_err got %b want 1", sel_err_b); else n_pass++;
    sel_b = 2'd1;
    step();
    in_valid_b = 1'b0;
    n_total++; if (out_data_b !== 8'h22 || sel_err_b !== 1'b0) $display("FAIL oor_next got data=%h err=%b want 22/0", out_data_b, sel_err_b); else n_pass++;
    step();
    n_total++; if (out_valid_b !== 1'b0) $display("FAIL oor_drain got %b want 0", out_valid_b); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; sel_a = 2'd0;
    step();
    sel_a = 2'd1;
    step();
    n_total++; if (in_ready_a !== 1'b0) $display("FAIL flush_pre_full got %b want 0", in_ready_a); else n_pass++;
    flush_a = 1'b1; sel_a = 2'd3;
    step();
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    n_total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) $display("FAIL flush_state got vld=%b rdy=%b want 0/1", out_valid_a, in_ready_a); else n_pass++;
    n_total++; if (sel_err_a !== 1'b0) $display("FAIL flush_sel_err got %b want 0", sel_err_a); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (out_valid_a !== 1'b0) $display("FAIL flush_leak cyc=%0d got vld=%b data=%h want 0", i, out_valid_a, out_data_a); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tbl [4];
    exp_tbl[0] = 32'hA; exp_tbl[1] = 32'hB; exp_tbl[2] = 32'hC; exp_tbl[3] = 32'hD;
    out_ready_a = 1'b1;
    in_valid_a = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      step();
      n_total++;
      if (out_valid_a !== 1'b1 || out_data_a !== exp_tbl[s] || in_ready_a !== 1'b1)
        $display("FAIL b2b sel=%0d got vld=%b data=%h rdy=%b want 1/%h/1", s, out_valid_a, out_data_a, in_ready_a, exp_tbl[s]);
      else n_pass++;
    end
    in_valid_a = 1'b0;
    step();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid_a); else n_pass++;
  endtask

  task automatic test_reset_in_two();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; sel_a = 2'd2;
    step();
    sel_a = 2'd3;
    step();
    n_total++; if (in_ready_a !== 1'b0) $display("FAIL rst2_pre_full got %b want 0", in_ready_a); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 || in_ready_a !== 1'b1)
      $display("FAIL rst2_state got vld=%b data=%h rdy=%b want 0/0/1", out_valid_a, out_data_a, in_ready_a); else n_pass++;
    sel_a = 2'd1; out_ready_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    n_total++; if (out_valid_a !== 1'b1 || out_data_a !== 32'hB) $display("FAIL rst2_first_accept got vld=%b data=%h want 1/b", out_valid_a, out_data_a); else n_pass++;
    step();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL rst2_drain got %b want 0", out_valid_a); else n_pass++;
  endtask

  initial begin
    in_data_a = {32'hD, 32'hC, 32'hB, 32'hA};
    in_data_b = {8'h33, 8'h22, 8'h11};
    sel_a = '0; in_valid_a = 1'b0; flush_a = 1'b0; out_ready_a = 1'b0;
    sel_b = '0; in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b0;
    rst = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_sel_err();
    test_flush();
    test_back_to_back();
    test_reset_in_two();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pipe_muxn

// File: doc/pipe_muxn.md
PIPE_MUXN -- requirements
Module: pipe_muxn

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each data input and of the output.
REQ-002 Parameter NUM_IN, default 4: number of selectable inputs; legal range 2..16.
REQ-003 Parameter SEL_WIDTH, default $clog2(NUM_IN): select width; shall not be overridden by the instantiator.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in_data  input  NUM_IN*DATA_WIDTH: flattened inputs; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 sel  input  SEL_WIDTH: input index; sampled together with in_data on acceptance.
REQ-008 in_valid  input  1: upstream offers in_data/sel.
REQ-009 in_ready  output  1: stage can accept; registered output.
REQ-010 flush  input  1: discard all held entries.
REQ-011 out_data  output  DATA_WIDTH: selected, registered data.
REQ-012 out_valid  output  1: out_data is valid.
REQ-013 out_ready  input  1: downstream accepts out_data.
REQ-014 sel_err  output  1: registered flag; the held output entry came from an out-of-range sel.

Function
REQ-015 Accept occurs on a cycle with in_valid=1 and in_ready=1; emit occurs on a cycle with out_valid=1 and out_ready=1.
REQ-016 Datapath: selected word = input[sel] when sel < NUM_IN; otherwise all zeros, with sel_err=1 stored alongside that entry.
REQ-017 Storage: main register (drives out_*) plus one skid register; state set {EMPTY, ONE, TWO}.
REQ-018 Latency: an accept in cycle N from EMPTY gives out_valid=1 with that word in cycle N+1.
REQ-019 EMPTY: accept -> ONE (load main).
REQ-020 ONE, accept without emit: -> TWO; load skid; in_ready=0 from the next cycle.
REQ-021 ONE, emit without accept: -> EMPTY.
REQ-022 ONE, simultaneous accept and emit: stay ONE; load main with the new word.
REQ-023 TWO: no accept is possible; on emit, skid moves to main -> ONE; in_ready=1 from the next cycle.
REQ-024 in_ready is high exactly when the state at the clock edge is not TWO.
REQ-025 Order is strictly FIFO; no entry is lost or duplicated while flush=0.
REQ-026 flush=1: next state EMPTY, out_valid=0, sel_err=0, in_ready=1; an accept or emit in the same cycle is discarded or ignored (flush wins).
REQ-027 out_data and sel_err shall hold their value while out_valid=1 and out_ready=0.
REQ-028 out_data is don't-care when out_valid=0, but shall not change on cycles with no state change.

Reset
REQ-029 rst=1 at a clock edge: state EMPTY, out_valid=0, out_data=0, sel_err=0, in_ready=1, skid register=0.
REQ-030 rst has priority over flush, accept and emit; any in-flight entries are dropped.
REQ-031 The first accept is possible on the first edge with rst=0.

Structure
REQ-032 The state enum (EMPTY/ONE/TWO) and the NUM_IN limit constants shall live in the shared package pipe_pkg.
REQ-033 The combinational N-way select with out-of-range detection shall be a sub-module muxn_sel (DATA_WIDTH, NUM_IN), instantiated once in front of the storage.
REQ-034 No latches; no combinational path from out_ready to in_ready.

Verification
REQ-035 NUM_IN=4, in_data={D,C,B,A}=32'hD,C,B,A, sel=2, in_valid pulse, out_ready=1 -> next cycle out_valid=1, out_data=32'hC, sel_err=0.
REQ-036 out_ready=0, three consecutive offers of sel=0,1,2 -> first two accepted, in_ready=0 for the third; then out_ready=1 -> outputs A, B, then C, in order.
REQ-037 NUM_IN=3, sel=3 accepted -> out_data=0 and sel_err=1 for that entry only; the following sel=1 entry has sel_err=0.
REQ-038 State TWO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the offered word never appears at the output.
REQ-039 Continuous in_valid=1 and out_ready=1 with a sel sweep 0..3 -> one output per cycle, in_ready stays 1, latency 1.
REQ-040 rst asserted while in state TWO -> next cycle out_valid=0, out_data=0, in_ready=1; accept works on the first cycle after rst deasserts.
